branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch predictor for the 5-stage RV32I pipeline. It replaces the fixed "predict not-taken, flush on every taken branch/jump" policy with a direct-mapped branch target buffer (BTB) and 2-bit bimodal counters. Lookup happens in Fetch and the predictor is trained from Execute. It also produces the redirect PC and the mispredict flush request used by the hazard unit, and keeps saturating performance counters.

## Interface
Parameters:
- ENTRIES, 64: BTB depth; power of 2, ≥ 4. IDX_W = log2(ENTRIES).
- TAG_W, 8: tag width. Tag = pc[IDX_W+1+TAG_W : IDX_W+2]. Index = pc[IDX_W+1:2].
- MODE, 1: 0 = static not-taken (BTB unused, o_pred_taken tied 0); 1 = bimodal BTB.
- CNT_W, 32: width of performance counters.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_pcF  in  32  Fetch-stage PC.
- o_pred_taken  out  1  Fetch prediction (combinational).
- o_pred_next_pc  out  32  o_pred_taken ? BTB target : i_pcF+4.
- i_upd_valid  in  1  Execute slot holds a real instruction (0 for bubbles and flushed slots).
- i_upd_pc  in  32  Execute-stage PC.
- i_upd_cti  in  1  Execute instruction is branch, JAL or JALR.
- i_upd_taken  in  1  resolved outcome (always 1 for JAL/JALR).
- i_upd_target  in  32  resolved target.
- i_upd_pred_taken  in  1  prediction carried down the pipe with this instruction.
- i_upd_pred_target  in  32  predicted next PC carried down the pipe.
- o_mispredict  out  1  flush F/D and redirect (combinational).
- o_redirect_pc  out  32  i_upd_taken&&i_upd_cti ? i_upd_target : i_upd_pc+4.
- o_branch_cnt  out  CNT_W  resolved CTIs.
- o_mispred_cnt  out  CNT_W  mispredicts.

## Operation
- Entry state: valid, tag[TAG_W], target[32], ctr[2].
- Lookup is combinational and reads the pre-update array state. A hit is valid && tag match.
- Prediction in MODE 1: o_pred_taken = hit && ctr[1]. In MODE 0: o_pred_taken = 0.
- Mispredict, evaluated when i_upd_valid:
  - CTI: pred_taken ≠ taken, or taken && pred_target ≠ target.
  - non-CTI: pred_taken = 1 (aliasing); redirect goes to pc+4.
  - o_mispredict is forced 0 while i_rst = 1.
- Update (MODE 1, i_upd_valid, not in reset); the BTB entry is indexed and tagged by i_upd_pc:
  - CTI taken, hit: ctr saturating increment (11 stays 11); target overwritten (covers JALR target changes).
  - CTI taken, miss: allocate/overwrite the entry: valid = 1, tag, target, ctr = 10.
  - CTI not-taken, hit: ctr saturating decrement (00 stays 00).
  - CTI not-taken, miss: no change.
  - non-CTI, hit: valid cleared.
  - non-CTI, miss: no change.
- MODE 0: the BTB is never written; mispredict and counters operate as normal.
- Counters (both modes), when i_upd_valid && not in reset:
  - o_branch_cnt +1 per CTI.
  - o_mispred_cnt +1 per mispredict.
  - Both saturate at all-ones.

## Timing
- Reset values: every valid = 0, every ctr = 01, both counters = 0.
  - Post-reset outputs: o_pred_taken = 0, o_pred_next_pc = i_pcF+4.
- Reset mid-operation: an update presented in the same cycle as i_rst is discarded. No BTB write, no count.
- Lookup latency is 0 cycles. An update becomes visible to lookup on the cycle after the edge that writes it.
- Same-index lookup and update in the same cycle: the lookup sees the old entry.
- o_mispredict and o_redirect_pc are combinational from the Execute inputs and are valid in the same cycle. The hazard unit flushes F/D and loads o_redirect_pc on the next edge.
- A stall does not gate the predictor. The pipeline deasserts i_upd_valid for E-stage bubbles, so a stalled instruction is trained exactly once.

## Test plan
Defaults unless stated: ENTRIES = 64, TAG_W = 8, MODE = 1.
1. Reset, then i_pcF = 0x100 → o_pred_taken = 0, o_pred_next_pc = 0x104, both counters = 0.
2. Taken-branch allocation and hit:
   - Stimulus: update pc = 0x100, cti = 1, taken = 1, target = 0x40, pred_taken = 0.
   - Same cycle: o_mispredict = 1, o_redirect_pc = 0x40.
   - Next cycle: lookup 0x100 → pred_taken = 1, next_pc = 0x40; o_branch_cnt = 1, o_mispred_cnt = 1.
3. Counter decay from the state of test 2 (ctr = 10):
   - One not-taken update at 0x100 → ctr = 01, lookup 0x100 → pred_taken = 0.
   - Second not-taken update → ctr = 00; one taken update → ctr = 01, still not-taken.
4. Tag aliasing: after test 2, lookup 0x4100 (same index, tag 0x41 ≠ 0x01) → pred_taken = 0, next_pc = 0x4104.
5. Non-CTI invalidation:
   - Stimulus: update pc = 0x100, cti = 0, pred_taken = 1, pred_target = 0x40.
   - Same cycle: o_mispredict = 1, o_redirect_pc = 0x104.
   - Next cycle: lookup 0x100 → miss, pred_taken = 0.
6. MODE = 0, CNT_W = 4:
   - 20 taken-branch updates → o_pred_taken stays 0, o_mispredict = 1 each time, o_mispred_cnt saturates at 15.
   - An update held during i_rst = 1 → counters stay 0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor
// Direct-mapped branch target buffer with 2-bit bimodal counters for the
// 5-stage RV32I pipeline. Fetch looks up the BTB combinationally, Execute
// trains it and resolves mispredicts. The block also produces the redirect PC
// for the hazard unit and keeps saturating CTI / mispredict counters.
// MODE 0 degrades to static not-taken: the BTB is never written and the
// prediction is tied low. Mispredict detection and counters still operate.

module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int MODE    = 1,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,

    // Fetch-side lookup
    input  logic [31:0]      i_pcF,
    output logic             o_pred_taken,
    output logic [31:0]      o_pred_next_pc,

    // Execute-side resolution and training
    input  logic             i_upd_valid,
    input  logic [31:0]      i_upd_pc,
    input  logic             i_upd_cti,
    input  logic             i_upd_taken,
    input  logic [31:0]      i_upd_target,
    input  logic             i_upd_pred_taken,
    input  logic [31:0]      i_upd_pred_target,
    output logic             o_mispredict,
    output logic [31:0]      o_redirect_pc,

    // Performance counters
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       CTR_INIT = 2'b01;  // weakly not-taken
    localparam logic [1:0]       CTR_NEW  = 2'b10;  // weakly taken
    localparam logic [1:0]       CTR_MAX  = 2'b11;
    localparam logic [1:0]       CTR_MIN  = 2'b00;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btb_entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    btb_entry_t       btb_q [ENTRIES];
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d;

    // ------------------------------------------------------------------
    // Fetch lookup: reads the array as it stood before this cycle's edge,
    // so a same-index update in the same cycle is not visible yet.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    btb_entry_t       f_entry;
    logic             f_hit;

    assign f_idx   = i_pcF[IDX_W+1:2];
    assign f_tag   = i_pcF[IDX_W+1+TAG_W:IDX_W+2];
    assign f_entry = btb_q[f_idx];
    assign f_hit   = f_entry.valid && (f_entry.tag == f_tag);

    assign o_pred_taken   = (MODE == 1) && f_hit && f_entry.ctr[1];
    assign o_pred_next_pc = o_pred_taken ? f_entry.target : (i_pcF + 32'd4);

    // ------------------------------------------------------------------
    // Execute-side entry decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic             upd_live;   // a real instruction that is allowed to train/count

    assign upd_idx   = i_upd_pc[IDX_W+1:2];
    assign upd_tag   = i_upd_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign upd_entry = btb_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign upd_live  = i_upd_valid && !i_rst;

    // Only some PC bits form index/tag; fold the rest into a sink.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_pcF, i_upd_pc};

    // ------------------------------------------------------------------
    // Mispredict detection: a CTI is wrong if direction differs or a taken
    // target differs; a non-CTI is wrong only if it was predicted taken
    // (BTB aliasing onto a non-branch).
    // ------------------------------------------------------------------
    logic mispredict;

    // Resolve the Execute-stage prediction against the real outcome.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        mispredict = 1'b0;
        if (upd_live) begin
            if (i_upd_cti) begin
                mispredict = (i_upd_pred_taken != i_upd_taken) ||
                             (i_upd_taken && (i_upd_pred_target != i_upd_target));
            end else begin
                mispredict = i_upd_pred_taken;
            end
        end
    end

    assign o_mispredict  = mispredict;
    assign o_redirect_pc = (i_upd_cti && i_upd_taken) ? i_upd_target
                                                      : (i_upd_pc + 32'd4);

    // ------------------------------------------------------------------
    // BTB training
    // ------------------------------------------------------------------
    logic       btb_we;
    btb_entry_t entry_d;

    // Compute the replacement entry and whether it is written this cycle.
    always_comb begin
        btb_we  = 1'b0;
        entry_d = upd_entry;
        if (upd_live && (MODE == 1)) begin
            if (i_upd_cti && i_upd_taken) begin
                btb_we = 1'b1;
                if (upd_hit) begin
                    // Strengthen and refresh the target (JALR targets move).
                    entry_d.ctr    = (upd_entry.ctr == CTR_MAX) ? CTR_MAX
                                                                : (upd_entry.ctr + 2'd1);
                    entry_d.target = i_upd_target;
                end else begin
                    // Allocate over whatever occupied this slot.
                    entry_d.valid  = 1'b1;
                    entry_d.tag    = upd_tag;
                    entry_d.target = i_upd_target;
                    entry_d.ctr    = CTR_NEW;
                end
            end else if (i_upd_cti) begin
                if (upd_hit) begin
                    btb_we      = 1'b1;
                    entry_d.ctr = (upd_entry.ctr == CTR_MIN) ? CTR_MIN
                                                             : (upd_entry.ctr - 2'd1);
                end
            end else if (upd_hit) begin
                // A non-CTI matched the BTB: drop the stale entry.
                btb_we        = 1'b1;
                entry_d.valid = 1'b0;
            end
        end
    end

    // BTB storage: cleared on reset, one entry written per cycle otherwise.
    // NOTE: the array is reset because the predictor must start with every
    // entry invalid and every counter at weakly-not-taken; a memory without
    // a defined reset would predict from garbage after power-up.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= CTR_INIT;
            end
        end else if (btb_we) begin
            btb_q[upd_idx] <= entry_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

    // Saturating increment of the CTI and mispredict counters.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_live) begin
            if (i_upd_cti && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + CNT_ONE;
            end
            if (mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_ONE;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (i_rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: a MODE 1 instance (defaults) and a MODE 0
// instance with 4-bit counters share one stimulus stream. Directed steps come
// first, then randomized traffic checked against a table-based model.

module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CNT1_W  = 32;
    localparam int CNT0_W  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_cti;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic              pt1, mp1;
    logic [31:0]       npc1, rpc1;
    logic [CNT1_W-1:0] bc1, mc1;
    logic              pt0, mp0;
    logic [31:0]       npc0, rpc0;
    logic [CNT0_W-1:0] bc0, mc0;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .MODE(1), .CNT_W(CNT1_W)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_pcF(pc_f),
        .o_pred_taken(pt1), .o_pred_next_pc(npc1),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_cti(upd_cti),
        .i_upd_taken(upd_taken), .i_upd_target(upd_target),
        .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
        .o_mispredict(mp1), .o_redirect_pc(rpc1),
        .o_branch_cnt(bc1), .o_mispred_cnt(mc1)
    );

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .MODE(0), .CNT_W(CNT0_W)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_pcF(pc_f),
        .o_pred_taken(pt0), .o_pred_next_pc(npc0),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_cti(upd_cti),
        .i_upd_taken(upd_taken), .i_upd_target(upd_target),
        .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
        .o_mispredict(mp0), .o_redirect_pc(rpc0),
        .o_branch_cnt(bc0), .o_mispred_cnt(mc0)
    );

    // ------------------------------------------------------------------
    // Reference model: a table of entries with an integer confidence 0..3
    // (predict taken at 2 or above) and plain integer counters.
    // ------------------------------------------------------------------
    typedef struct {
        bit          valid;
        int unsigned tag;
        logic [31:0] target;
        int          conf;
    } m_entry_t;

    m_entry_t m_btb [ENTRIES];
    longint   m_bcnt1, m_mcnt1, m_bcnt0, m_mcnt0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_btb[idx_of(pc)].valid && (m_btb[idx_of(pc)].tag == tag_of(pc));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && (m_btb[idx_of(pc)].conf >= 2);
    endfunction

    function automatic logic [31:0] m_next_pc(logic [31:0] pc);
        return m_pred(pc) ? m_btb[idx_of(pc)].target : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        if (rst || !upd_valid) return 1'b0;
        if (upd_cti)
            return (upd_pred_taken != upd_taken) ||
                   (upd_taken && (upd_pred_target != upd_target));
        return upd_pred_taken;
    endfunction

    function automatic logic [31:0] m_redirect();
        return (upd_cti && upd_taken) ? upd_target : upd_pc + 32'd4;
    endfunction

    function automatic longint bump(longint v, int w);
        longint lim = (longint'(1) << w) - 1;
        return (v >= lim) ? lim : v + 1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_btb[i].valid  = 1'b0;
            m_btb[i].tag    = 0;
            m_btb[i].target = '0;
            m_btb[i].conf   = 1;
        end
        m_bcnt1 = 0; m_mcnt1 = 0; m_bcnt0 = 0; m_mcnt0 = 0;
    endfunction

    function automatic void m_update();
        int i   = idx_of(upd_pc);
        bit hit = m_hit(upd_pc);
        bit mis = m_mispredict();
        if (upd_cti) begin
            m_bcnt1 = bump(m_bcnt1, CNT1_W);
            m_bcnt0 = bump(m_bcnt0, CNT0_W);
        end
        if (mis) begin
            m_mcnt1 = bump(m_mcnt1, CNT1_W);
            m_mcnt0 = bump(m_mcnt0, CNT0_W);
        end
        if (upd_cti && upd_taken) begin
            if (hit) begin
                m_btb[i].conf   = (m_btb[i].conf < 3) ? m_btb[i].conf + 1 : 3;
                m_btb[i].target = upd_target;
            end else begin
                m_btb[i].valid  = 1'b1;
                m_btb[i].tag    = tag_of(upd_pc);
                m_btb[i].target = upd_target;
                m_btb[i].conf   = 2;
            end
        end else if (upd_cti) begin
            if (hit) m_btb[i].conf = (m_btb[i].conf > 0) ? m_btb[i].conf - 1 : 0;
        end else if (hit) begin
            m_btb[i].valid = 1'b0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, take the edge,
    // advance the model, then check registered counters.
    task automatic tick(bit comb_ok = 1'b1);
        #1;
        if (comb_ok) begin
            check("pred_taken_m1", pt1, m_pred(pc_f));
            check("pred_next_m1", npc1, m_next_pc(pc_f));
            check("pred_taken_m0", pt0, 1'b0);
            check("pred_next_m0", npc0, pc_f + 32'd4);
            check("mispredict_m1", mp1, m_mispredict());
            check("mispredict_m0", mp0, m_mispredict());
            check("redirect_m1", rpc1, m_redirect());
            check("redirect_m0", rpc0, m_redirect());
        end
        @(posedge clk);
        if (rst) m_reset();
        else if (upd_valid) m_update();
        #1;
        check("branch_cnt_m1", bc1, m_bcnt1);
        check("mispred_cnt_m1", mc1, m_mcnt1);
        check("branch_cnt_m0", bc0, m_bcnt0);
        check("mispred_cnt_m0", mc0, m_mcnt0);
    endtask

    task automatic drive(bit v, logic [31:0] pc, bit cti, bit tk, logic [31:0] tgt,
                         bit ptk, logic [31:0] ptgt);
        upd_valid = v; upd_pc = pc; upd_cti = cti; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 2)) << (2 + IDX_W)) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        m_reset();
        rst = 1'b1;
        pc_f = 32'h100;
        idle();
        @(negedge clk);
        tick(1'b0);
        tick();

        // Post-reset lookup
        rst = 1'b0;
        pc_f = 32'h100;
        #1;
        check("reset_pred_taken", pt1, 1'b0);
        check("reset_next_pc", npc1, 32'h104);
        check("reset_branch_cnt", bc1, 0);
        check("reset_mispred_cnt", mc1, 0);
        tick();

        // Taken-branch allocation; the same-cycle lookup sees the old entry
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
        #1;
        check("alloc_mispredict", mp1, 1'b1);
        check("alloc_redirect", rpc1, 32'h40);
        check("alloc_same_cycle_pred", pt1, 1'b0);
        tick();
        idle();
        #1;
        check("alloc_hit_pred", pt1, 1'b1);
        check("alloc_hit_next", npc1, 32'h40);
        check("alloc_branch_cnt", bc1, 1);
        check("alloc_mispred_cnt", mc1, 1);

        // Tag alias at the same index
        pc_f = 32'h4100;
        #1;
        check("alias_pred", pt1, 1'b0);
        check("alias_next", npc1, 32'h4104);
        tick();

        // Counter decay: 10 -> 01 -> 00 -> 01
        pc_f = 32'h100;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
        tick();
        idle();
        #1;
        check("decay_once_pred", pt1, 1'b0);
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 1'b0, 32'h104);
        tick();
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
        tick();
        idle();
        #1;
        check("decay_recover_pred", pt1, 1'b0);
        tick();

        // Non-CTI invalidation
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        #1;
        check("noncti_mispredict", mp1, 1'b1);
        check("noncti_redirect", rpc1, 32'h104);
        tick();
        idle();
        #1;
        check("noncti_invalidated", pt1, 1'b0);
        tick();

        // Twenty taken branches: MODE 0 never predicts and saturates at 15
        for (int i = 0; i < 20; i++) begin
            pc_f = 32'h200 + 32'(i * 4);
            drive(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b1, 32'h800, 1'b0, 32'h204 + 32'(i * 4));
            #1;
            check("m0_pred_stays_0", pt0, 1'b0);
            check("m0_mispredict", mp0, 1'b1);
            tick();
        end
        idle();
        check("m0_mispred_sat", mc0, 4'hf);
        check("m0_branch_sat", bc0, 4'hf);

        // An update held during reset is discarded
        rst = 1'b1;
        drive(1'b1, 32'h300, 1'b1, 1'b1, 32'h900, 1'b0, 32'h304);
        #1;
        check("rst_mispredict_forced", mp1, 1'b0);
        tick();
        check("rst_m0_mispred_cnt", mc0, 0);
        check("rst_m0_branch_cnt", bc0, 0);
        check("rst_m1_branch_cnt", bc1, 0);
        rst = 1'b0;
        idle();
        pc_f = 32'h300;
        #1;
        check("rst_no_btb_write", pt1, 1'b0);
        tick();

        // Randomized traffic over a small PC set so entries hit and alias
        for (int n = 0; n < 500; n++) begin
            logic [31:0] pc;
            bit          cti;
            bit          tk;
            logic [31:0] tgt;
            pc   = rand_pc();
            cti  = ($urandom_range(0, 9) < 7);
            tk   = cti && ($urandom_range(0, 1) == 1);
            tgt  = rand_pc() + 32'h1000;
            rst  = ($urandom_range(0, 99) == 0);
            pc_f = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
            if ($urandom_range(0, 1) == 1)
                drive($urandom_range(0, 9) < 8, pc, cti, tk, tgt, m_pred(pc), m_next_pc(pc));
            else
                drive($urandom_range(0, 9) < 8, pc, cti, tk, tgt,
                      1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? tgt : rand_pc());
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
